time_display_scan: RTL and testbench
====================================

# time_display_scan

Multiplexed six-digit seven-segment driver placed directly downstream of `time_view`. It consumes the packed BCD time `hh_mm_ss`, the `am_pm` flag, the 12/24-hour mode and a per-field blink mask. It scans one digit at a time onto shared active-low segment lines, with a dead cycle between digits and frame-coherent input sampling. The 12h/24h formatting, PM indicator, separators and set-mode blinking are all handled here.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per digit slot; legal range ≥ 2.
- `BLINK_FRAMES`, default 64: scan frames per blink half-period; legal range ≥ 1.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `hh_mm_ss`, input, 20: packed BCD time, laid out as follows.
  - [19:18] hours tens, [17:14] hours units.
  - [13:11] minutes tens, [10:7] minutes units.
  - [6:4] seconds tens, [3:0] seconds units.
- `am_pm`, input, 1: 1 = PM; meaningful only in 12h mode.
- `mode12h`, input, 1: 1 = 12-hour formatting.
- `blink_mask`, input, 3: bit2 = hours, bit1 = minutes, bit0 = seconds. A set bit blanks that field during the blink-off phase.
- `an`, output, 6: digit enables, active-low, at most one low.
- `seg`, output, 7: `{g,f,e,d,c,b,a}`, active-low.
- `dp`, output, 1: decimal point, active-low.
- `frame_start`, output, 1: single-cycle pulse in the first cycle of each frame.

## Operation
- **Digit index `idx`:** digits 0..5 are seconds units, seconds tens, minutes units, minutes tens, hours units, hours tens.
- **Counters:**
  - Prescaler `pc` counts 0..SCAN_DIV-1.
  - `idx` advances when `pc` wraps, and wraps 5→0.
  - Frame = 6·SCAN_DIV cycles.
- **Snapshot:** `hh_mm_ss`, `am_pm`, `mode12h` and `blink_mask` load into a snapshot register on the edge leaving (`idx`=5, `pc`=SCAN_DIV-1). Input changes inside a frame are never visible until the next frame.
- **Slot behaviour:**
  - `pc`=0 is the dead cycle: `an`=6'b111111, `seg`=7'h7F, `dp`=1.
  - For `pc`≥1: `an` drives bit `idx` low, and `seg`/`dp` are decoded from the snapshot digit `idx`.
- **Decode:**
  - Values 0–9 map to the standard glyphs.
  - An out-of-range digit shows a dash (`seg`=7'b0111111). Out of range means units >9, hours tens >2, or minutes/seconds tens >5.
- **12h mode** (snapshot `mode12h`=1): digit 5 is blanked (`seg`=7'h7F, `an` still driven) when hours tens = 0.
- **`dp` rules:**
  - `dp` is low on digits 2 and 4 (HH.MM.SS separators) in both modes.
  - `dp` is low on digit 0 iff snapshot `mode12h`=1 and `am_pm`=1.
  - `dp` is high on all other digits.
- **Blink:**
  - The frame counter toggles `blink_on` every BLINK_FRAMES frames; reset value is `blink_on`=1 (visible).
  - While `blink_on`=0, the digits of every field whose snapshot mask bit is set output `seg`=7'h7F and `dp`=1, with `an` still driven.
- **Reset:**
  - Outputs: `an`=6'b111111, `seg`=7'h7F, `dp`=1, `frame_start`=0.
  - Internal state: `pc`=0, `idx`=0, frame counter 0, `blink_on`=1, snapshot all-zero.
  - The first frame after reset therefore shows 00.00.00 in 24h format.
  - Reset asserted mid-frame forces these values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered and computed from the next-state `pc`/`idx`.
- `frame_start`=1 exactly in the cycle `idx`=0, `pc`=0, which is also the cycle the new snapshot first holds.
- Digit `k` is lit in cycles `pc`=1..SCAN_DIV-1 of slot `k`, so the duty is (SCAN_DIV-1)/(6·SCAN_DIV).
- Blink phase changes only at frame boundaries; no partial-frame blink.
- There is no handshake: the upstream stage may change inputs at any cycle.

## Structure
- **Shared package `clock_pkg`:** BCD field bit positions for `hh_mm_ss`, constants SEG_BLANK (7'h7F) and SEG_DASH (7'b0111111), digit index constants, and field/mask bit indices.
- **Sub-module `seg7_decode`:** combinational; takes a 4-bit value plus a max-legal-value input and produces 7-bit active-low segments (glyph or dash).
- **Top level:** holds the counters, snapshot, blink logic and output registers.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.
1. **Reset:**
   - Stimulus: `rst`=1 asynchronously mid-scan.
   - Required: `an`=111111, `seg`=7'h7F, `dp`=1, `frame_start`=0 at once.
   - After release: frame 0 shows `seg`=1000000 on all six digits.
2. **Glyph decode, 24h:**
   - Stimulus: 24h mode, time 12:34:56.
   - Required `seg` for digits 0..5: 0000010, 0010010, 0011001, 0110000, 0100100, 1111001.
   - Required `dp` low on digits 2 and 4 only.
   - Required: a dead cycle with `an`=111111 before each digit.
3. **Frame coherence:** change `hh_mm_ss` while `idx`=3 → digits 3–5 keep the old values; the new value appears from the next `frame_start`.
4. **12h formatting:** `mode12h`=1, `am_pm`=1, hours 07 → digit 5 `seg`=7'h7F; digit 0 `dp`=0.
5. **Blink:** `blink_mask`=3'b010 → digits 2–3 blank in frames 2–3 and visible in frames 0–1 and 4–5; other digits unaffected.
6. **Invalid BCD:** seconds units = 4'hA, minutes tens = 3'd6 → digits 0 and 3 show `seg`=0111111.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time display path: BCD field layout of hh_mm_ss,
// segment constants, digit indices, field/mask bit indices and the snapshot type.
// No ports; imported by seg7_decode and time_display_scan.
package clock_pkg;

  // hh_mm_ss BCD field positions
  localparam int HT_LSB = 18;  // hours tens   [19:18]
  localparam int HT_W   = 2;
  localparam int HU_LSB = 14;  // hours units  [17:14]
  localparam int MT_LSB = 11;  // minutes tens [13:11]
  localparam int MT_W   = 3;
  localparam int MU_LSB = 7;   // minutes units [10:7]
  localparam int ST_LSB = 4;   // seconds tens [6:4]
  localparam int ST_W   = 3;
  localparam int SU_LSB = 0;   // seconds units [3:0]
  localparam int UNIT_W = 4;

  // Largest legal value per digit kind
  localparam logic [3:0] MAX_UNIT = 4'd9;
  localparam logic [3:0] MAX_HR_T = 4'd2;
  localparam logic [3:0] MAX_MS_T = 4'd5;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit scan order
  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  // Field / blink_mask bit indices
  localparam logic [1:0] FLD_SEC = 2'd0;
  localparam logic [1:0] FLD_MIN = 2'd1;
  localparam logic [1:0] FLD_HR  = 2'd2;

  // Inputs captured once per frame
  typedef struct packed {
    logic [19:0] hms;
    logic        am_pm;
    logic        mode12h;
    logic [2:0]  mask;
  } snap_t;

  // Each field owns two consecutive digits, so the field is idx/2.
  function automatic logic [1:0] field_of(input logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose: BCD digit to active-low seven-segment glyph, dash when value > i_max.
// Ports: i_val (4-bit digit), i_max (largest legal value), o_seg ({g,f,e,d,c,b,a}).
// Latency: combinational; no backpressure.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic [3:0] i_max,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_val <= i_max) begin
      case (i_val)
        4'd0:    o_seg = 7'b1000000;
        4'd1:    o_seg = 7'b1111001;
        4'd2:    o_seg = 7'b0100100;
        4'd3:    o_seg = 7'b0110000;
        4'd4:    o_seg = 7'b0011001;
        4'd5:    o_seg = 7'b0010010;
        4'd6:    o_seg = 7'b0000010;
        4'd7:    o_seg = 7'b1111000;
        4'd8:    o_seg = 7'b0000000;
        4'd9:    o_seg = 7'b0010000;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Purpose: six-digit multiplexed 7-seg scanner with frame snapshot, 12h format, dp and blink.
// Ports: clk/rst; hh_mm_ss, am_pm, mode12h, blink_mask in; an, seg, dp (active-low), frame_start out.
// Latency: outputs registered from next-state counters; no handshake, inputs sampled once per frame.
module time_display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] hh_mm_ss,
  input  logic        am_pm,
  input  logic        mode12h,
  input  logic [2:0]  blink_mask,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PC_W = $clog2(SCAN_DIV);
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_idx;
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_blink_on;
  snap_t           r_snap;

  logic [PC_W-1:0] w_pc_nxt;
  logic [2:0]      w_idx_nxt;
  logic            w_pc_wrap;
  logic            w_frame_end;
  logic [3:0]      w_dig_val;
  logic [3:0]      w_dig_max;
  logic [6:0]      w_dec_seg;
  logic            w_hidden;
  logic [5:0]      w_an_d;
  logic [6:0]      w_seg_d;
  logic            w_dp_d;

  assign w_pc_wrap   = (r_pc == PC_LAST);
  assign w_frame_end = w_pc_wrap && (r_idx == DIG_HR_T);
  assign w_pc_nxt    = w_pc_wrap ? '0 : r_pc + 1'b1;
  assign w_idx_nxt   = !w_pc_wrap    ? r_idx :
                       w_frame_end   ? DIG_SEC_U : r_idx + 3'd1;

  // Digit selection from the frame snapshot; tens fields are zero-extended.
  always_comb begin
    w_dig_val = r_snap.hms[SU_LSB +: UNIT_W];
    w_dig_max = MAX_UNIT;
    case (w_idx_nxt)
      DIG_SEC_T: begin
        w_dig_val = {1'b0, r_snap.hms[ST_LSB +: ST_W]};
        w_dig_max = MAX_MS_T;
      end
      DIG_MIN_U: w_dig_val = r_snap.hms[MU_LSB +: UNIT_W];
      DIG_MIN_T: begin
        w_dig_val = {1'b0, r_snap.hms[MT_LSB +: MT_W]};
        w_dig_max = MAX_MS_T;
      end
      DIG_HR_U:  w_dig_val = r_snap.hms[HU_LSB +: UNIT_W];
      DIG_HR_T: begin
        w_dig_val = {2'b00, r_snap.hms[HT_LSB +: HT_W]};
        w_dig_max = MAX_HR_T;
      end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .i_val (w_dig_val),
    .i_max (w_dig_max),
    .o_seg (w_dec_seg)
  );

  // Next output values. pc_nxt==0 is the dead cycle between digits; when
  // pc_nxt!=0 no frame boundary is crossed, so the registered snapshot and
  // blink phase are the ones belonging to the digit being lit.
  always_comb begin
    w_an_d   = 6'h3F;
    w_seg_d  = SEG_BLANK;
    w_dp_d   = 1'b1;
    w_hidden = !r_blink_on && r_snap.mask[field_of(w_idx_nxt)];
    if (w_pc_nxt != '0) begin
      w_an_d = ~(6'b000001 << w_idx_nxt);
      if (!w_hidden) begin
        w_seg_d = w_dec_seg;
        // 12h leading-zero suppression on hours tens
        if (w_idx_nxt == DIG_HR_T && r_snap.mode12h &&
            r_snap.hms[HT_LSB +: HT_W] == 2'd0)
          w_seg_d = SEG_BLANK;
        if (w_idx_nxt == DIG_MIN_U || w_idx_nxt == DIG_HR_U)
          w_dp_d = 1'b0;
        // PM indicator rides on the rightmost decimal point
        if (w_idx_nxt == DIG_SEC_U && r_snap.mode12h && r_snap.am_pm)
          w_dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_idx       <= DIG_SEC_U;
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_snap      <= '0;
      an          <= 6'h3F;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_idx <= w_idx_nxt;
      if (w_frame_end) begin
        r_snap <= '{hms: hh_mm_ss, am_pm: am_pm, mode12h: mode12h, mask: blink_mask};
        if (r_frame_cnt == FC_LAST) begin
          r_frame_cnt <= '0;
          r_blink_on  <= !r_blink_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      an          <= w_an_d;
      seg         <= w_seg_d;
      dp          <= w_dp_d;
      frame_start <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan (SCAN_DIV=4, BLINK_FRAMES=2).
// A driver pushes each frame's expected outputs when it fixes the inputs the
// frame will capture; a monitor pops and compares one entry per clock cycle.
module tb_time_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = 6 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] hh_mm_ss;
  logic        am_pm, mode12h;
  logic [2:0]  blink_mask;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_start;

  time_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .hh_mm_ss(hh_mm_ss), .am_pm(am_pm), .mode12h(mode12h),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  typedef struct packed {
    logic [19:0] t;
    logic        pm;
    logic        m12;
    logic [2:0]  mask;
  } in_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  // Expected outputs at position pos (0..FL-1) of frame number frame.
  function automatic exp_t model(input in_t s, input int frame, input int pos);
    exp_t e;
    int slot, sub, val, maxv;
    bit hidden;
    slot  = pos / SD;
    sub   = pos % SD;
    e.an  = 6'h3F;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fs  = (pos == 0) && (frame > 0);
    if (sub == 0) return e;
    e.an = ~(6'd1 << slot);
    case (slot)
      0: begin val = int'(s.t[3:0]);   maxv = 9; end
      1: begin val = int'(s.t[6:4]);   maxv = 5; end
      2: begin val = int'(s.t[10:7]);  maxv = 9; end
      3: begin val = int'(s.t[13:11]); maxv = 5; end
      4: begin val = int'(s.t[17:14]); maxv = 9; end
      default: begin val = int'(s.t[19:18]); maxv = 2; end
    endcase
    hidden = (((frame / BF) % 2) == 1) && s.mask[slot / 2];
    if (hidden) return e;
    e.seg = (val > maxv) ? 7'b0111111 : glyph(val);
    if (slot == 5 && s.m12 && val == 0) e.seg = 7'h7F;
    e.dp = !(slot == 2 || slot == 4 || (slot == 0 && s.m12 && s.pm));
    return e;
  endfunction

  // Inputs that frame f should display (directed first, then random).
  function automatic in_t target(input int f);
    in_t r;
    r.pm = 1'b0; r.m12 = 1'b0; r.mask = 3'b000;
    case (f)
      1: begin r.t = bcd(12, 34, 56); r.mask = 3'b010; end
      2: begin r.t = bcd(7, 15, 9); r.m12 = 1'b1; r.pm = 1'b1; r.mask = 3'b010; end
      3: r.t = {2'd1, 4'd0, 3'd6, 4'd2, 3'd3, 4'hA};
      4, 5, 6, 7: begin r.t = bcd(23, 59, 48); r.mask = 3'b010; end
      default: begin
        if ($urandom_range(0, 4) == 0) r.t = 20'($urandom);
        else r.t = bcd($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        r.pm   = 1'($urandom);
        r.m12  = 1'($urandom);
        r.mask = 3'($urandom);
      end
    endcase
    return r;
  endfunction

  task automatic apply(input in_t v);
    hh_mm_ss   = v.t;
    am_pm      = v.pm;
    mode12h    = v.m12;
    blink_mask = v.mask;
  endtask

  task automatic push_frame(input in_t s, input int f);
    for (int p = 0; p < FL; p++) q.push_back(model(s, f, p));
  endtask

  task automatic check_reset(input string name);
    n_tests++;
    if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b want an=111111 seg=1111111 dp=1 fs=0",
               name, an, seg, dp, frame_start);
    end
  endtask

  // Releases reset on a falling edge and runs ncyc cycles of drive + monitor.
  task automatic run_seg(input int ncyc);
    q.delete();
    push_frame('0, 0);
    @(negedge clk);
    rst = 1'b0;
    fork
      begin : driver
        in_t tgt;
        int  off;
        off = 0;
        for (int c = 0; c < ncyc; c++) begin
          int f, pos;
          if (c > 0) @(negedge clk);
          f   = c / FL;
          pos = c % FL;
          if (pos == 0) begin
            off = $urandom_range(0, FL - 1);
            tgt = target(f + 1);
          end
          // Junk before the real value lands; none of it may reach the display.
          if (pos < off && $urandom_range(0, 2) == 0) apply(in_t'({$urandom, $urandom}));
          if (pos == off) apply(tgt);
          if (pos == FL - 1) push_frame(tgt, f + 1);
        end
      end
      begin : monitor
        for (int c = 0; c < ncyc; c++) begin
          exp_t e;
          if (c > 0) @(negedge clk);
          #1;
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL cyc%0d: scoreboard empty, got an=%b seg=%b", c, an, seg);
          end else begin
            e = q.pop_front();
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
              n_fail++;
              $display("FAIL cyc%0d frame%0d pos%0d: got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                       c, c / FL, c % FL, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
          end
        end
      end
    join
  endtask

  initial begin
    rst = 1'b1;
    apply(target(9));
    #1;
    check_reset("reset_at_start");
    repeat (3) @(posedge clk);

    run_seg(12 * FL + 10);

    // Mid-digit asynchronous reset, away from any clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_reset_mid_scan");
    repeat (2) @(posedge clk);
    check_reset("reset_held");

    run_seg(30 * FL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
